// File: rtl/objdma_pkg.sv
// ---------------------------------------------------------------------------
// objdma_pkg
//   Definitions shared by the object DMA sequencer and its read pipeline:
//   the FSM state encoding, the default DMA window bounds, and the window
//   compare helper.
// ---------------------------------------------------------------------------
package objdma_pkg;

    // Default vertical DMA window. Both bounds are inclusive.
    localparam int DMA_VSTART_DEF = 479;
    localparam int DMA_VEND_DEF   = 494;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;  // waiting for window && pending
    localparam state_t ST_REQ  = 3'd1;  // BUSRQ raised, waiting for BUSAK
    localparam state_t ST_COPY = 3'd2;  // bus owned, streaming words
    localparam state_t ST_REL  = 3'd3;  // dropping BUSRQ/BUSY
    localparam state_t ST_WAIT = 3'd4;  // hold off until the window closes

    // True when the vertical count lies inside [lo, hi].
    function automatic logic in_win(input logic [8:0] v, input int lo, input int hi);
        int vi;
        vi = int'({23'd0, v});
        return (vi >= lo) && (vi <= hi);
    endfunction

endpackage

// File: rtl/objdma_rdpipe.sv
// ---------------------------------------------------------------------------
// objdma_rdpipe
//   Tracks source reads that are in flight. Each CE tick the read strobe and
//   its word address enter stage 0 and move one stage further; the last
//   stage lines up with the source data, LAT ticks after the read.
//   A flush drops every in-flight valid so aborted reads never turn into
//   destination writes.
// Ports
//   clk_i    master clock
//   rst_i    synchronous reset, active-high
//   ce_i     clock enable; the pipe only shifts on CE
//   flush_i  discard all in-flight reads (sampled on CE)
//   vld_i    read issued this tick
//   addr_i   word address of that read
//   vld_o    data for a read returns this tick
//   addr_o   word address belonging to the returning data
// ---------------------------------------------------------------------------
module objdma_rdpipe #(
    parameter int LAT = 1,
    parameter int AW  = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          flush_i,
    input  logic          vld_i,
    input  logic [AW-1:0] addr_i,
    output logic          vld_o,
    output logic [AW-1:0] addr_o
);

    logic [LAT-1:0]         vld_pipe_q;
    logic [LAT-1:0][AW-1:0] addr_pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else if (ce_i) begin
            vld_pipe_q[0]  <= vld_i & ~flush_i;
            addr_pipe_q[0] <= addr_i;
            for (int k = 1; k < LAT; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1] & ~flush_i;
                addr_pipe_q[k] <= addr_pipe_q[k-1];
            end
        end
    end

    assign vld_o  = vld_pipe_q[LAT-1];
    assign addr_o = addr_pipe_q[LAT-1];

endmodule

// File: rtl/objdma_ctrl.sv
// ---------------------------------------------------------------------------
// objdma_ctrl
//   Once-per-frame object DMA. When armed by the CPU it requests the CPU bus
//   inside the vertical DMA window, copies WORDS words from the CPU-side
//   object buffer into the sprite engine's object RAM, and releases the bus.
//   If the window closes before the copy finishes the transfer is abandoned,
//   OVERRUN is flagged and the copy is retried from word 0 next frame.
// Ports
//   i_EMU_MCLK         master clock
//   i_MRST             synchronous reset, active-high
//   i_EMU_CLK6MPCEN_n  pixel clock enable, active-low; all state moves on CE
//   i_VCOUNTER         vertical count from the timing generator
//   i_DMA_ARM          CPU request for a DMA in the next window
//   o_BUSRQ / i_BUSAK  CPU bus request / acknowledge
//   o_SRC_ADDR/_RD     object buffer read port
//   i_SRC_DATA         object buffer data, RD_LAT ticks after the read
//   o_DST_ADDR/_DATA/_WE  object RAM write port
//   o_BUSY             bus held (request through release)
//   o_DONE             one-tick pulse after the last word is written
//   o_OVERRUN          sticky abort flag, cleared by the next arm
// ---------------------------------------------------------------------------
module objdma_ctrl
    import objdma_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int WORDS      = 1024,
    parameter int DMA_VSTART = DMA_VSTART_DEF,
    parameter int DMA_VEND   = DMA_VEND_DEF,
    parameter int RD_LAT     = 1
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_MRST,
    input  logic              i_EMU_CLK6MPCEN_n,
    input  logic [8:0]        i_VCOUNTER,
    input  logic              i_DMA_ARM,
    output logic              o_BUSRQ,
    input  logic              i_BUSAK,
    output logic [ADDR_W-1:0] o_SRC_ADDR,
    output logic              o_SRC_RD,
    input  logic [DATA_W-1:0] i_SRC_DATA,
    output logic [ADDR_W-1:0] o_DST_ADDR,
    output logic [DATA_W-1:0] o_DST_DATA,
    output logic              o_DST_WE,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_OVERRUN
);

    // Counters carry one extra bit so WORDS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] WORDS_C = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(WORDS - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic ce;
    logic win;

    state_t          state_q,   state_d;
    logic            pending_q, pending_d;
    logic            busrq_q,   busrq_d;
    logic            overrun_q, overrun_d;
    logic            done_q,    done_d;
    logic [ADDR_W:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0] wr_cnt_q,  wr_cnt_d;

    logic              rd_fire;
    logic              wr_fire;
    logic              abort;
    logic              pipe_vld;
    logic [ADDR_W-1:0] pipe_addr;

    assign ce  = ~i_EMU_CLK6MPCEN_n;
    assign win = in_win(i_VCOUNTER, DMA_VSTART, DMA_VEND);

    // Copy-phase events. A closed window overrides everything in COPY:
    // no new read and no write of returning data on the abort tick.
    assign abort   = (state_q == ST_COPY) && !win;
    assign rd_fire = (state_q == ST_COPY) && win && i_BUSAK && (rd_addr_q < WORDS_C);
    assign wr_fire = (state_q == ST_COPY) && win && pipe_vld;

    objdma_rdpipe #(
        .LAT (RD_LAT),
        .AW  (ADDR_W)
    ) u_rdpipe (
        .clk_i   (i_EMU_MCLK),
        .rst_i   (i_MRST),
        .ce_i    (ce),
        .flush_i (abort),
        .vld_i   (rd_fire),
        .addr_i  (rd_addr_q[ADDR_W-1:0]),
        .vld_o   (pipe_vld),
        .addr_o  (pipe_addr)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | i_DMA_ARM;
        busrq_d   = busrq_q;
        overrun_d = overrun_q & ~i_DMA_ARM;
        done_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_cnt_d  = wr_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // An arm landing on the window's first tick still counts.
                if (win && (pending_q || i_DMA_ARM)) begin
                    state_d = ST_REQ;
                    busrq_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (!win) begin
                    // Bus never granted in time; keep pending for next frame.
                    overrun_d = 1'b1;
                    busrq_d   = 1'b0;
                    state_d   = ST_IDLE;
                end else if (i_BUSAK) begin
                    state_d   = ST_COPY;
                    rd_addr_d = '0;
                    wr_cnt_d  = '0;
                    pending_d = i_DMA_ARM;
                end
            end
            ST_COPY: begin
                if (abort) begin
                    overrun_d = 1'b1;
                    pending_d = 1'b1;
                    state_d   = ST_REL;
                end else begin
                    if (rd_fire)
                        rd_addr_d = rd_addr_q + ONE_C;
                    if (wr_fire) begin
                        wr_cnt_d = wr_cnt_q + ONE_C;
                        if (wr_cnt_q == LAST_C) begin
                            done_d  = 1'b1;
                            state_d = ST_REL;
                        end
                    end
                end
            end
            ST_REL: begin
                busrq_d = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // At most one DMA per window.
                if (!win)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busrq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_MRST) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            busrq_q   <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_cnt_q  <= '0;
        end else if (ce) begin
            state_q   <= state_d;
            pending_q <= pending_d;
            busrq_q   <= busrq_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            rd_addr_q <= rd_addr_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Strobes are gated by reset as well so a reset mid-copy kills the
    // write already in its own cycle.
    assign o_SRC_RD   = ce & ~i_MRST & rd_fire;
    assign o_SRC_ADDR = rd_addr_q[ADDR_W-1:0];
    assign o_DST_WE   = ce & ~i_MRST & wr_fire;
    assign o_DST_ADDR = pipe_addr;
    assign o_DST_DATA = o_DST_WE ? i_SRC_DATA : '0;
    assign o_BUSRQ    = busrq_q;
    assign o_BUSY     = busrq_q;
    assign o_DONE     = done_q;
    assign o_OVERRUN  = overrun_q;

endmodule
